// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start/DBIT data (LSB first)/stop framing.
// rx is double-flopped before use; dout, frame_err and rx_done_tick are registered.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err
);

  localparam int SW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
  localparam int NW = ($clog2(DBIT) < 1) ? 1 : $clog2(DBIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_shreg;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;
  logic            r_rx_meta;
  logic            r_rx_sync;
  logic            w_rx_s;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx_s = r_rx_sync;

  // Frame FSM with tick/bit counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == SW'(7)) begin
              // A start bit that is already high at its midpoint was a glitch
              if (!w_rx_s) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == SW'(15)) begin
              r_s     <= '0;
              r_shreg <= {w_rx_s, r_shreg[DBIT-1:1]};
              if (r_n == NW'(DBIT - 1)) begin
                r_state <= STOP;
              end else begin
                r_n <= r_n + NW'(1);
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (r_s == SW'(SB_TICK - 1)) begin
              r_state <= IDLE;
              r_dout  <= r_shreg;
              r_ferr  <= ~w_rx_s;
              r_done  <= 1'b1;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: s_tick every 4 clk, one bit period = 64 clk.
// A negedge monitor counts rx_done_tick strobes and flags back-to-back strobes.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       s_tick;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;

  int checks;
  int errors;
  int strobes;
  int consec;
  logic prev_done;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running oversampling strobe: one clk high out of every four
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  // Strobe monitor, sampled on the falling edge
  initial begin
    strobes   = 0;
    consec    = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        strobes = strobes + 1;
        if (prev_done === 1'b1) consec = consec + 1;
      end
      prev_done = rx_done_tick;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(64);
    end
    rx = stop_val;
    wait_clk(stop_len);
    rx = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rx     = 1'b1;
    reset  = 1'b0;

    // Reset held for 5 clk while rx toggles
    for (int i = 0; i < 5; i++) begin
      wait_clk(1);
      rx = ~rx;
    end
    chk("rst_dout",  32'(dout), 32'h00);
    chk("rst_done",  32'(rx_done_tick), 32'h0);
    chk("rst_ferr",  32'(frame_err), 32'h0);
    chk("rst_strb",  32'(strobes), 32'd0);
    rx = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(128);

    // Single good frame
    send_frame(8'hA5, 1'b1, 64);
    wait_clk(64);
    chk("a5_strb", 32'(strobes), 32'd1);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_ferr", 32'(frame_err), 32'h0);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 64);
    chk("b2b0_strb", 32'(strobes), 32'd2);
    chk("b2b0_dout", 32'(dout), 32'h00);
    send_frame(8'hFF, 1'b1, 64);
    wait_clk(64);
    chk("b2b1_strb", 32'(strobes), 32'd3);
    chk("b2b1_dout", 32'(dout), 32'hFF);
    chk("b2b1_ferr", 32'(frame_err), 32'h0);

    // Start-bit glitch: low for 5 ticks only
    rx = 1'b0;
    wait_clk(20);
    rx = 1'b1;
    wait_clk(128);
    chk("glitch_strb", 32'(strobes), 32'd3);
    chk("glitch_dout", 32'(dout), 32'hFF);

    // Stop bit driven low
    send_frame(8'h3C, 1'b0, 48);
    wait_clk(128);
    chk("ferr_strb", 32'(strobes), 32'd4);
    chk("ferr_dout", 32'(dout), 32'h3C);
    chk("ferr_flag", 32'(frame_err), 32'h1);

    // Next good frame clears frame_err
    send_frame(8'h81, 1'b1, 64);
    wait_clk(64);
    chk("clr_strb", 32'(strobes), 32'd5);
    chk("clr_dout", 32'(dout), 32'h81);
    chk("clr_ferr", 32'(frame_err), 32'h0);

    // Reset after start + 4 data bits aborts the frame silently
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      wait_clk(64);
    end
    reset = 1'b0;
    rx    = 1'b1;
    wait_clk(5);
    reset = 1'b1;
    wait_clk(128);
    chk("abort_strb", 32'(strobes), 32'd5);
    chk("abort_dout", 32'(dout), 32'h00);
    chk("abort_done", 32'(rx_done_tick), 32'h0);
    send_frame(8'h5A, 1'b1, 64);
    wait_clk(64);
    chk("5a_strb", 32'(strobes), 32'd6);
    chk("5a_dout", 32'(dout), 32'h5A);
    chk("5a_ferr", 32'(frame_err), 32'h0);

    // Break: line held low, one zero frame with frame error
    rx = 1'b0;
    wait_clk(680);
    chk("brk_strb", 32'(strobes), 32'd7);
    chk("brk_dout", 32'(dout), 32'h00);
    chk("brk_ferr", 32'(frame_err), 32'h1);
    // Release mid-start of the re-entered frame: all data bits read high
    rx = 1'b1;
    wait_clk(700);
    chk("brkrel_strb", 32'(strobes), 32'd8);
    chk("brkrel_dout", 32'(dout), 32'hFF);
    chk("brkrel_ferr", 32'(frame_err), 32'h0);

    chk("no_consec", 32'(consec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
